// File: rtl/img_frame_streamer.sv
// Replays one WIDTH x HEIGHT frame from a 1-cycle-latency pixel buffer into the
// writer's vld/dout stream, with VSYNC/HSYNC idle gaps ahead of the rows.
module img_frame_streamer #(
  parameter int WIDTH       = 128,
  parameter int HEIGHT      = 128,
  parameter int VSYNC_DELAY = 200,
  parameter int HSYNC_DELAY = 160,
  parameter int DW          = 8,
  parameter int AW          = (WIDTH * HEIGHT > 1) ? $clog2(WIDTH * HEIGHT) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] base_addr,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic          vld,
  output logic [DW-1:0] dout,
  output logic          busy,
  output logic          frame_done
);

  localparam int DLY_MAX = (VSYNC_DELAY > HSYNC_DELAY) ? VSYNC_DELAY : HSYNC_DELAY;
  localparam int CW      = $clog2(DLY_MAX + 1);
  localparam int COLW    = $clog2(WIDTH + 1);
  localparam int ROWW    = $clog2(HEIGHT + 1);

  localparam logic [CW-1:0]   V_LAST = CW'(VSYNC_DELAY - 1);
  localparam logic [CW-1:0]   H_LAST = CW'(HSYNC_DELAY - 1);
  localparam logic [COLW-1:0] C_LAST = COLW'(WIDTH - 1);
  localparam logic [ROWW-1:0] R_LAST = ROWW'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, VSYNC, HSYNC, ACTIVE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   dly_cnt;
  logic [COLW-1:0] col;
  logic [ROWW-1:0] row;
  logic [AW-1:0]   addr;
  logic            end_pend;
  logic [DW-1:0]   dout_q;
  logic            accept, last_rd, abort_eff;

  // busy spans the drain of the last beat and the frame_done cycle
  assign busy      = (state != IDLE) || end_pend || frame_done;
  assign abort_eff = abort && busy;
  assign accept    = (state == IDLE) && start && !abort && !busy;
  assign last_rd   = (state == ACTIVE) && (col == C_LAST) && (row == R_LAST);
  assign mem_rd_en = (state == ACTIVE);
  assign mem_addr  = addr;
  // buffer data arrives in the vld cycle; dout_q holds it between beats
  assign dout      = vld ? mem_rdata : dout_q;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (accept) state_nxt = VSYNC;
      VSYNC:  if (dly_cnt == V_LAST) state_nxt = HSYNC;
      HSYNC:  if (dly_cnt == H_LAST) state_nxt = ACTIVE;
      ACTIVE: if (col == C_LAST) state_nxt = (row == R_LAST) ? IDLE : HSYNC;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dly_cnt    <= '0;
      col        <= '0;
      row        <= '0;
      addr       <= '0;
      end_pend   <= 1'b0;
      frame_done <= 1'b0;
      vld        <= 1'b0;
      dout_q     <= '0;
    end else begin
      vld <= mem_rd_en;
      if (vld) dout_q <= mem_rdata;

      end_pend   <= last_rd && !abort_eff;
      frame_done <= end_pend && !abort_eff;

      if ((state == VSYNC || state == HSYNC) && state_nxt == state) dly_cnt <= dly_cnt + 1'b1;
      else                                                         dly_cnt <= '0;

      if (state == ACTIVE && state_nxt == ACTIVE) col <= col + 1'b1;
      else                                        col <= '0;

      if (state_nxt == IDLE)                           row <= '0;
      else if (state == ACTIVE && state_nxt == HSYNC)  row <= row + 1'b1;

      // rows are contiguous, so a running pointer equals base + row*WIDTH + col
      if (abort_eff)               addr <= '0;
      else if (accept)             addr <= base_addr;
      else if (state == ACTIVE)    addr <= addr + 1'b1;
    end
  end

endmodule

// File: tb/tb_img_frame_streamer.sv
// Scoreboard bench for img_frame_streamer on a 4x3 frame with 5/2 sync gaps.
module tb_img_frame_streamer;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int VD = 5;
  localparam int HD = 2;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int FIRST_VLD = 2 + VD + HD;
  localparam int DONE_CYC  = 1 + VD + H * HD + W * H + 1;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic          vld;
  logic [DW-1:0] dout;
  logic          busy;
  logic          frame_done;

  logic [DW-1:0] mem [16];
  int  edges = 0;
  int  org = 0;
  int  total = 0;
  int  bad = 0;
  bit  fill_alt = 1'b0;

  typedef struct {int e; int d;} beat_t;
  beat_t bq[$];
  int    dq[$];
  beat_t mb;
  int    md;

  img_frame_streamer #(
    .WIDTH(W), .HEIGHT(H), .VSYNC_DELAY(VD), .HSYNC_DELAY(HD), .DW(DW), .AW(AW)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .base_addr(base_addr),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .vld(vld), .dout(dout), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (edge %0d)", name, act, exp, edges);
    end
  endtask

  function automatic int pix(input int a);
    return fill_alt ? (((a % 16) * 7 + 3) % 256) : (a % 16);
  endfunction

  task automatic load_mem();
    for (int i = 0; i < 16; i++) mem[i] = DW'(pix(i));
  endtask

  // call while positioned in the cycle whose closing edge should accept start
  task automatic start_frame(input int base, input int nbeats, input bit with_done);
    base_addr = AW'(base);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    org = edges;
    for (int i = 0; i < nbeats; i++) begin
      int r, c;
      r = i / W;
      c = i % W;
      bq.push_back('{org + FIRST_VLD + r * (W + HD) + c - 1, pix(base + i)});
    end
    if (with_done) dq.push_back(org + DONE_CYC - 1);
  endtask

  task automatic wait_cycle(input int k);
    do @(negedge clk); while (edges - org + 1 < k);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vld"}, vld, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, frame_done, 0);
    chk({tag, "_rd_en"}, mem_rd_en, 0);
    chk({tag, "_dout"}, dout, 0);
    chk({tag, "_addr"}, mem_addr, 0);
  endtask

  always @(negedge clk) begin
    if (vld) begin
      if (bq.size() == 0) chk("unexpected_beat", vld, 0);
      else begin
        mb = bq.pop_front();
        chk("beat_edge", edges, mb.e);
        chk("beat_data", dout, mb.d);
      end
    end
    if (frame_done) begin
      if (dq.size() == 0) chk("unexpected_done", frame_done, 0);
      else begin
        md = dq.pop_front();
        chk("done_edge", edges, md);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired edges=%0d", edges);
    $fatal(1, "watchdog");
  end

  initial begin
    load_mem();
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rstn = 1'b1;
    @(negedge clk);

    // frame 1 with ignored start pulses at cycles 10 and 25
    start_frame(0, W * H, 1'b1);
    wait_cycle(1);  chk("busy_c1", busy, 1);
    wait_cycle(10); pulse_start();
    wait_cycle(25); chk("busy_c25", busy, 1);
    pulse_start();
    wait_cycle(26); chk("busy_c26", busy, 0);
    chk("f1_beats_left", bq.size(), 0);
    chk("f1_done_left", dq.size(), 0);

    // frame 2 started at cycle 26, aborted at cycle 16 of its own timeline
    start_frame(0, 7, 1'b0);
    wait_cycle(16); abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    wait_cycle(17);
    chk("abort_busy", busy, 0);
    chk("abort_rd_en", mem_rd_en, 0);
    wait_cycle(30);
    chk("abort_beats_left", bq.size(), 0);
    chk("abort_done_left", dq.size(), 0);

    // frame 3: base wraps around the 16-entry buffer
    fill_alt = 1'b1;
    load_mem();
    @(negedge clk);
    start_frame(13, W * H, 1'b1);
    wait_cycle(8);  chk("wrap_addr_c8", mem_addr, 13);
    wait_cycle(11); chk("wrap_addr_c11", mem_addr, 0);
    wait_cycle(26);
    chk("wrap_busy_c26", busy, 0);
    chk("wrap_beats_left", bq.size(), 0);
    chk("wrap_done_left", dq.size(), 0);

    // frame 4: async reset at cycle 20
    @(negedge clk);
    start_frame(0, 8, 1'b0);
    wait_cycle(20);
    chk("pre_reset_rd_en", mem_rd_en, 1);
    rstn = 1'b0;
    #1 chk_all_zero("midreset");
    @(negedge clk);
    rstn = 1'b1;
    repeat (30) @(negedge clk);
    chk("midreset_beats_left", bq.size(), 0);
    chk("midreset_done_left", dq.size(), 0);

    // start and abort together in IDLE: start dropped
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("start_abort_busy", busy, 0);
    repeat (20) @(negedge clk);
    chk("start_abort_rd_en", mem_rd_en, 0);

    // frame 5: clean full frame after all of the above
    start_frame(0, W * H, 1'b1);
    wait_cycle(25); chk("f5_busy_c25", busy, 1);
    wait_cycle(26); chk("f5_busy_c26", busy, 0);
    chk("f5_beats_left", bq.size(), 0);
    chk("f5_done_left", dq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/img_frame_streamer.md
Name: img_frame_streamer

Overview:
Synthesizable frame sequencer that reads one raster image from a pixel buffer and replays it into the BMP image writer's vld/din stream. It uses the same frame/line timing the writer expects: a VSYNC gap, then per row an HSYNC gap followed by WIDTH back-to-back pixels. It sits between the on-chip image buffer (1-cycle read latency) and bmp_image_writer, and is started and stopped by the top-level controller.

Parameters:
WIDTH, 128, pixels per row (>=1)
HEIGHT, 128, rows per frame (>=1)
VSYNC_DELAY, 200, idle cycles before first row (>=1)
HSYNC_DELAY, 160, idle cycles before each row (>=1)
DW, 8, pixel width
AW, $clog2(WIDTH*HEIGHT) (localparam-derived default), buffer address width

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
start  input  1  1-cycle frame request; sampled only when busy=0
abort  input  1  synchronous frame cancel
base_addr  input  AW  frame base in buffer, latched on accepted start
mem_rd_en  output  1  buffer read strobe
mem_addr  output  AW  buffer read address
mem_rdata  input  DW  buffer data, valid 1 cycle after mem_rd_en
vld  output  1  pixel valid to writer
dout  output  DW  pixel data to writer
busy  output  1  frame in progress
frame_done  output  1  1-cycle pulse, frame complete

Behaviour:
- Reset (rstn=0, async): state=IDLE; all counters 0; mem_rd_en, mem_addr, vld, dout, busy, frame_done = 0.
- FSM states: IDLE, VSYNC, HSYNC, ACTIVE.
- IDLE: start=1 and abort=0 at edge 0 -> latch base_addr, enter VSYNC. busy=1 from cycle 1.
- VSYNC: exactly VSYNC_DELAY cycles -> HSYNC (row=0).
- HSYNC: exactly HSYNC_DELAY cycles, mem_rd_en=0 -> ACTIVE (col=0).
- ACTIVE: exactly WIDTH cycles. mem_rd_en=1. mem_addr = base + row*WIDTH + col, computed modulo 2^AW (wraps, no error).
  - At col=WIDTH-1: if row<HEIGHT-1, increment row and go to HSYNC; otherwise go to IDLE.
- Output stage (1-cycle latency):
  - vld(t+1) = mem_rd_en(t).
  - dout(t+1) = mem_rdata when mem_rd_en(t)=1; otherwise dout holds its last value.
  - vld is low in every VSYNC/HSYNC cycle.
- Timing with start sampled at edge 0:
  - first mem_rd_en at cycle 1+VSYNC_DELAY+HSYNC_DELAY
  - first vld one cycle later
  - last vld at cycle L = 1 + VSYNC_DELAY + HEIGHT*HSYNC_DELAY + WIDTH*HEIGHT
  - frame_done=1 only at cycle L+1
  - busy=1 for cycles 1..L+1 inclusive, 0 at L+2
- Exactly WIDTH*HEIGHT vld beats per frame. Gap between rows is exactly HSYNC_DELAY cycles of vld=0.
- start while busy=1 (including the frame_done cycle) is ignored, not queued.
- abort=1 while busy:
  - next cycle: state=IDLE, mem_rd_en=0, busy=0, counters cleared.
  - The final in-flight vld beat (read issued in the abort cycle) still appears next cycle; nothing after it.
  - No frame_done pulse.
- abort in IDLE: no effect. start and abort high together in IDLE: abort wins, start is dropped.
- Async reset mid-frame: immediate return to reset values; no frame_done.

Test Plan:
- WIDTH=4, HEIGHT=3, VSYNC=5, HSYNC=2, buffer[i]=i, base=0, start at edge 0 -> vld at cycles 9-12, 15-18, 21-24 with dout 0..11 in order; frame_done only at 25; busy 1..25.
- Same params, base=2^AW-3 -> addresses wrap: 13,14,15,0,1,...; dout follows buffer[(base+i) mod 16].
- start re-pulsed at cycles 10 and 25 -> ignored, exactly 12 beats; start at 26 -> second frame, first vld at 35.
- abort asserted at cycle 16 (mid row 1) -> last vld at cycle 17 (dout=6), busy=0 at 17, no frame_done, next start accepted normally.
- rstn pulsed low at cycle 20 -> all outputs 0 immediately; after release, start yields a clean full frame matching the first scenario's timing.
- Defaults (128x128, 200/160), butterfly image preloaded into the buffer, feeding bmp_image_writer -> 16384 beats, frame_done at cycle 1+200+20480+16384+1=37066, writer's frame_done fires, output BMP matches the golden image.
